// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared widths, default constants, FSM state type and the PC increment
//   helper used by the fetch sequencer slice.
package fetch_sequencer_pkg;

  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned INSTR_W = 16;

  localparam logic [ADDR_W-1:0]  DEF_RESET_PC   = 13'h0000;
  localparam logic [INSTR_W-1:0] DEF_HALT_INSTR = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  // Wraps modulo 2^ADDR_W by construction of the result width.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Bundles the sequencer's control, instruction-memory, decode and
//   PC-register signals.
//   master : the fetch sequencer (drives imem_req/addr, ir_*, pc_*, halted, err)
//   slave  : the surrounding CPU / memory (drives start, stall, br_*, imem_ack/rdata)
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic               start;
  logic               stall;
  logic               br_valid;
  logic [ADDR_W-1:0]  br_target;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               ir_valid;
  logic [INSTR_W-1:0] ir_data;
  logic [ADDR_W-1:0]  ir_pc;
  logic               pc_chosen;
  logic               pc_w_en;
  logic [ADDR_W-1:0]  pc_w_data;
  logic               halted;
  logic               err;

  modport master (
    input  start, stall, br_valid, br_target, imem_ack, imem_rdata,
    output imem_req, imem_addr, ir_valid, ir_data, ir_pc,
           pc_chosen, pc_w_en, pc_w_data, halted, err
  );

  modport slave (
    output start, stall, br_valid, br_target, imem_ack, imem_rdata,
    input  imem_req, imem_addr, ir_valid, ir_data, ir_pc,
           pc_chosen, pc_w_en, pc_w_data, halted, err
  );

endinterface

// File: rtl/fetch_sequencer_pc_next.sv
// fetch_sequencer_pc_next
//   Combinational next-PC select: redirect target, wrapping increment, or hold.
//   i_pc      current PC
//   i_sel_br  take i_target (has priority over increment)
//   i_sel_inc take i_pc + 1 (mod 2^ADDR_W)
//   i_target  redirect address
//   o_pc_next selected next PC
module fetch_sequencer_pc_next
  import fetch_sequencer_pkg::*;
(
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_sel_br,
  input  logic              i_sel_inc,
  input  logic [ADDR_W-1:0] i_target,
  output logic [ADDR_W-1:0] o_pc_next
);

  always_comb begin
    o_pc_next = i_pc;
    if (i_sel_br) begin
      o_pc_next = i_target;
    end else if (i_sel_inc) begin
      o_pc_next = pc_incr(i_pc);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch sequencer and program-counter source. Issues one fetch
//   at a time, hands the fetched word to decode and writes the next PC into
//   the PC register whenever the PC advances.
//   clk  rising-edge clock
//   rst  asynchronous reset, active-low
//   bus  fetch_sequencer_if.master: start/stall/br_* control, imem_* fetch
//        handshake, ir_* decode output, pc_* PC-register write port,
//        halted and err status
//   Optional macro FETCH_ERR_EN: when defined, err flags acks outside WAIT
//   and X on control/ack/data (simulation-only); otherwise err is tied 0.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC   = DEF_RESET_PC,
  parameter logic [INSTR_W-1:0] HALT_INSTR = DEF_HALT_INSTR
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_ir_data;
  logic [ADDR_W-1:0]  r_ir_pc;
  logic               r_redir_pend;
  logic [ADDR_W-1:0]  r_redir_tgt;

  logic [ADDR_W-1:0]  w_target;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic               w_pc_we;
  logic               w_sel_br;
  logic               w_sel_inc;
  logic               w_capture;
  logic               w_pend_set;
  logic               w_pend_clr;

  // A live redirect this cycle beats one latched earlier during the fetch.
  assign w_target = bus.br_valid ? bus.br_target : r_redir_tgt;

  fetch_sequencer_pc_next u_pc_next (
    .i_pc      (r_pc),
    .i_sel_br  (w_sel_br),
    .i_sel_inc (w_sel_inc),
    .i_target  (w_target),
    .o_pc_next (w_pc_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_we     = 1'b0;
    w_sel_br    = 1'b0;
    w_sel_inc   = 1'b0;
    w_capture   = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_REQ;
      end
      // The request already issued must complete, so a redirect seen while
      // it is outstanding is only remembered; the PC moves when the ack
      // retires the (discarded) word.
      ST_REQ: begin
        w_state_nxt = ST_WAIT;
        if (bus.br_valid) w_pend_set = 1'b1;
      end
      ST_WAIT: begin
        if (bus.imem_ack) begin
          if (bus.br_valid || r_redir_pend) begin
            w_sel_br    = 1'b1;
            w_pc_we     = 1'b1;
            w_pend_clr  = 1'b1;
            w_state_nxt = ST_REQ;
          end else if (bus.imem_rdata == HALT_INSTR) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end else if (bus.br_valid) begin
          w_pend_set = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (bus.br_valid) begin
          w_sel_br    = 1'b1;
          w_pc_we     = 1'b1;
          w_state_nxt = ST_REQ;
        end else if (!bus.stall) begin
          w_sel_inc   = 1'b1;
          w_pc_we     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_HALT: ;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_ir_data    <= '0;
      r_ir_pc      <= '0;
      r_redir_pend <= 1'b0;
      r_redir_tgt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pc_we) r_pc <= w_pc_nxt;
      if (w_capture) begin
        r_ir_data <= bus.imem_rdata;
        r_ir_pc   <= r_pc;
      end
      if (w_pend_set) begin
        r_redir_pend <= 1'b1;
        r_redir_tgt  <= bus.br_target;
      end else if (w_pend_clr) begin
        r_redir_pend <= 1'b0;
      end
    end
  end

  assign bus.imem_req  = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign bus.imem_addr = r_pc;
  assign bus.ir_valid  = (r_state == ST_ISSUE);
  assign bus.ir_data   = r_ir_data;
  assign bus.ir_pc     = r_ir_pc;
  assign bus.pc_w_en   = w_pc_we;
  assign bus.pc_chosen = w_pc_we;
  assign bus.pc_w_data = w_pc_we ? w_pc_nxt : '0;
  assign bus.halted    = (r_state == ST_HALT);

`ifdef FETCH_ERR_EN
  always_comb begin
    bus.err = 1'b0;
    if ((bus.imem_ack === 1'b1) && (r_state != ST_WAIT)) bus.err = 1'b1;
    if ($isunknown({bus.br_valid, bus.stall, bus.imem_ack})) bus.err = 1'b1;
    if ((bus.imem_ack === 1'b1) && $isunknown(bus.imem_rdata)) bus.err = 1'b1;
  end
`else
  assign bus.err = 1'b0;
`endif

endmodule
